i2s_dac_tx: RTL and testbench
=============================

# i2s_dac_tx

I2S transmitter for the codec DAC path. It accepts parallel stereo frames from the effect chain through a valid/ready handshake and buffers them in a small frame FIFO. It serializes each frame MSB-first onto DACDAT, aligned to the codec-driven DACLRCK. It is the transmit counterpart of the ADC-side I2S receiver and sits between the final effect stage and the codec pins.

## Interface
- DATA_W, 16: sample width in bits, two's complement.
- FIFO_DEPTH, 2: FIFO depth in stereo frames; power of two, at least 2.

- i_AUD_BCLK  in  1  bit clock, sole clock; all logic on posedge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_AUD_DACLRCK  in  1  codec word clock; low = left channel, high = right channel.
- i_en  in  1  transmit enable.
- i_valid  in  1  frame offered on i_left/i_right.
- o_ready  out  1  frame can be accepted this cycle.
- i_left  in  DATA_W  left sample.
- i_right  in  DATA_W  right sample.
- o_AUD_DACDAT  out  1  serial data, registered.
- o_frame_start  out  1  one-cycle pulse when a frame is popped for transmission.
- o_underrun  out  1  sticky flag: a left slot started with the FIFO empty.
- i_clr_underrun  in  1  clears o_underrun.

## Operation
- Reset values: o_AUD_DACDAT=0, o_ready=1, o_frame_start=0, o_underrun=0; FIFO empty; held sample 0; state WAIT_SYNC.
- Push: the FIFO accepts a frame when i_valid && o_ready.
  - o_ready = !full, evaluated on the occupancy at the start of the cycle.
  - A full FIFO never accepts a frame, even if a pop happens in the same cycle.
- Edge detect:
  - lrck_prev registers i_AUD_DACLRCK.
  - Left start: lrck_prev=1 and lrck=0.
  - Right start: lrck_prev=0 and lrck=1.
- State machine:
  - WAIT_SYNC: o_AUD_DACDAT=0. Move to LEFT on the first left start. A right start is ignored, so no partial frame is ever sent.
  - LEFT: on entry, pop one frame and load the left sample into the shift register. Move to RIGHT on right start.
  - RIGHT: on entry, load the right sample of the frame popped at the preceding left start. Move to LEFT on left start.
  - Any state: i_en=0 returns the block to WAIT_SYNC at the next cycle.
- Pop and underrun:
  - At a left start with i_en=1 and the FIFO non-empty, pop the frame and pulse o_frame_start.
  - At a left start with the FIFO empty, the transmitted frame follows the configured underrun rule and o_underrun is set.
  - A push in the same cycle as the pop is not bypassed; an empty FIFO at that edge still underruns.
- Serialization:
  - The MSB is driven in the edge-detect cycle.
  - Each following cycle shifts left by one bit.
  - After DATA_W bits, drive 0 until the next LRCK edge.
  - If LRCK toggles before DATA_W bits are sent, the remaining bits are dropped and the new slot starts immediately.
- o_underrun: set has priority over i_clr_underrun when both occur in the same cycle.
- i_en=0: FIFO is neither popped nor flushed and push continues; DACDAT=0 and no underrun is flagged.

## Timing
- DACDAT changes on posedge; the codec samples it on the following rising edge.
- MSB is therefore sampled on the 2nd rising BCLK after the LRCK transition, giving standard I2S 1-bit delay.
- Push-to-air latency: the frame is popped at the first left start after acceptance, not in the same cycle. Its MSB is on DACDAT in that cycle.
- Throughput: one frame per LRCK period. The FIFO absorbs up to FIFO_DEPTH frames of producer jitter.
- Reset mid-slot: DACDAT drops to 0 asynchronously. The block resynchronizes on the next left start.

## Configuration
- I2S_DAC_TX_UNDERRUN_HOLD_EN defined: on underrun, retransmit the last successfully popped frame (both channels). After reset with no frame ever popped, this frame is 0.
- Not defined: on underrun, transmit 0 in both channels.
- In both cases o_underrun is set identically.

## Structure
- Shared package aud_pkg:
  - typedef aud_frame_t, a packed struct {left, right} of DATA_W each.
  - the tx state enum.
  - localparam AUD_DATA_W = 16.
- Sub-module aud_frame_fifo: synchronous FIFO of aud_frame_t with push/pop/full/empty, reused later by the receive side.
- The shifter and FSM live in i2s_dac_tx.

## Test plan
- Reset, then push L=16'h8001, R=16'h7FFE; drive LRCK with 32 BCLKs per slot.
  - Bits sampled from the 2nd rising edge of each slot reproduce 8001 and 7FFE.
  - o_frame_start pulses exactly once.
- Start LRCK high after reset.
  - DACDAT stays 0 through the right slot.
  - The first frame appears only after the first falling LRCK.
- Push 3 frames back-to-back with FIFO_DEPTH=2.
  - o_ready deasserts after 2 pushes; the 3rd is held off until a pop.
  - The frames are transmitted in order.
- Stop pushing after frame L=16'h1234.
  - The next left slot sets o_underrun.
  - With the macro it sends 1234; without it, it sends 0000.
  - i_clr_underrun then clears the flag.
- Use 10 BCLKs per slot with DATA_W=16.
  - Only the 10 MSBs are sent.
  - The right slot starts cleanly with its MSB.
- Assert reset mid-left-slot.
  - DACDAT=0 and o_ready=1 immediately.
  - The next frame is aligned to the following left start.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared audio-path package: frame type, transmit state encoding and the
// common sample width used by the I2S transmit and receive blocks.
package aud_pkg;

  // Native sample width of the audio path (two's complement).
  localparam int AUD_DATA_W = 16;

  // One stereo frame; left occupies the upper half of the packed vector.
  typedef struct packed {
    logic [AUD_DATA_W-1:0] left;
    logic [AUD_DATA_W-1:0] right;
  } aud_frame_t;

  // I2S transmit slot tracking.
  typedef enum logic [1:0] {
    TX_WAIT_SYNC = 2'd0,
    TX_LEFT      = 2'd1,
    TX_RIGHT     = 2'd2
  } aud_tx_state_t;

endpackage

// File: rtl/aud_frame_fifo.sv
// Synchronous stereo-frame FIFO with push/pop/full/empty.
// A push is refused while full and a pop is refused while empty, so the
// caller may present requests without pre-qualifying them. The element type
// is a parameter so the receive side can reuse it with its own frame layout.
// DEPTH must be a power of two so the pointers wrap naturally.
module aud_frame_fifo
  import aud_pkg::*;
#(
  parameter int  DEPTH  = 2,
  parameter type elem_t = aud_frame_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  elem_t push_data,
  input  logic  pop,
  output elem_t pop_data,
  output logic  full,
  output logic  empty
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1'b1);
  localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(1'b0);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  // Storage is only ever read while the FIFO holds data, so it needs no reset.
  elem_t         mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Status flags come straight from the registered occupancy.
  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == CNT_ZERO);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign pop_data  = mem_r[rd_ptr_r];

  // Write accepted frames into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Advance the pointers on accepted push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Track occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the codec DAC path.
// Frames from the effect chain are buffered in aud_frame_fifo and shifted
// out MSB-first on DACDAT, aligned to the codec-driven DACLRCK (low = left).
// The MSB is registered in the cycle that detects the LRCK edge, so the
// codec samples it on the second rising BCLK: standard 1-bit I2S delay.
// Build option: define I2S_DAC_TX_UNDERRUN_HOLD_EN to repeat the last popped
// frame on underrun; otherwise an underrun frame is transmitted as silence.
module i2s_dac_tx
  import aud_pkg::*;
#(
  parameter int DATA_W     = AUD_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              i_AUD_BCLK,
  input  logic              i_rst_n,
  input  logic              i_AUD_DACLRCK,
  input  logic              i_en,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  output logic              o_AUD_DACDAT,
  output logic              o_frame_start,
  output logic              o_underrun,
  input  logic              i_clr_underrun
);

  // Frame layout at this instance's sample width.
  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } frame_t;

  logic          lrck_prev_r;
  logic          left_start_s;
  logic          right_start_s;
  aud_tx_state_t state_r;
  aud_tx_state_t state_nxt_s;

  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          push_s;
  logic          pop_s;
  frame_t        push_frame_s;
  frame_t        fifo_frame_s;

  logic          slot_left_s;
  logic          slot_right_s;
  logic          underrun_set_s;
  frame_t        tx_frame_s;
  frame_t        held_frame_r;

  logic [DATA_W-1:0] shift_r;
  logic              dacdat_r;
  logic              frame_start_r;
  logic              underrun_r;

  // Slot boundaries: falling LRCK opens a left slot, rising a right slot.
  assign left_start_s  = lrck_prev_r & ~i_AUD_DACLRCK;
  assign right_start_s = ~lrck_prev_r & i_AUD_DACLRCK;

  // A left slot is acted on in any state; a right slot only completes a
  // frame whose left half was sent, so no partial frame leaves the block.
  assign slot_left_s    = i_en & left_start_s;
  assign slot_right_s   = i_en & right_start_s & (state_r == TX_LEFT);
  assign pop_s          = slot_left_s & ~fifo_empty_s;
  assign underrun_set_s = slot_left_s & fifo_empty_s;

  // Ready reflects the occupancy at the start of the cycle; a full FIFO
  // refuses a push even when a pop happens in the same cycle.
  assign o_ready      = ~fifo_full_s;
  assign push_s       = i_valid & ~fifo_full_s;
  assign push_frame_s = '{left: i_left, right: i_right};

  assign o_AUD_DACDAT  = dacdat_r;
  assign o_frame_start = frame_start_r;
  assign o_underrun    = underrun_r;

  aud_frame_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .elem_t (frame_t)
  ) u_fifo (
    .clk       (i_AUD_BCLK),
    .rst_n     (i_rst_n),
    .push      (push_s),
    .push_data (push_frame_s),
    .pop       (pop_s),
    .pop_data  (fifo_frame_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Remember the previous LRCK level for edge detection.
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrck_prev_r <= 1'b0;
    end else begin
      lrck_prev_r <= i_AUD_DACLRCK;
    end
  end

  // Choose the frame for a starting left slot: popped data, or the underrun rule.
  always_comb begin
    tx_frame_s = held_frame_r;
    if (pop_s) begin
      tx_frame_s = fifo_frame_s;
    end else begin
`ifdef I2S_DAC_TX_UNDERRUN_HOLD_EN
      tx_frame_s = held_frame_r;
`else
      tx_frame_s = '0;
`endif
    end
  end

  // Slot state register.
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= TX_WAIT_SYNC;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; dropping the enable always falls back to WAIT_SYNC.
  always_comb begin
    state_nxt_s = state_r;
    if (!i_en) begin
      state_nxt_s = TX_WAIT_SYNC;
    end else begin
      case (state_r)
        TX_WAIT_SYNC: begin
          if (left_start_s) begin
            state_nxt_s = TX_LEFT;
          end else begin
            state_nxt_s = TX_WAIT_SYNC;
          end
        end
        TX_LEFT: begin
          if (right_start_s) begin
            state_nxt_s = TX_RIGHT;
          end else if (left_start_s) begin
            state_nxt_s = TX_LEFT;
          end else begin
            state_nxt_s = TX_LEFT;
          end
        end
        TX_RIGHT: begin
          if (left_start_s) begin
            state_nxt_s = TX_LEFT;
          end else begin
            state_nxt_s = TX_RIGHT;
          end
        end
        default: begin
          state_nxt_s = TX_WAIT_SYNC;
        end
      endcase
    end
  end

  // Hold the frame in flight so its right half is available at the right slot.
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      held_frame_r <= '0;
    end else if (slot_left_s) begin
      held_frame_r <= tx_frame_s;
    end
  end

  // Serializer: load the MSB on the slot edge, then shift zeros in behind it.
  // A new slot edge reloads immediately, discarding any unsent bits.
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_r  <= '0;
      dacdat_r <= 1'b0;
    end else if (!i_en) begin
      shift_r  <= '0;
      dacdat_r <= 1'b0;
    end else if (slot_left_s) begin
      dacdat_r <= tx_frame_s.left[DATA_W-1];
      shift_r  <= {tx_frame_s.left[DATA_W-2:0], 1'b0};
    end else if (slot_right_s) begin
      dacdat_r <= held_frame_r.right[DATA_W-1];
      shift_r  <= {held_frame_r.right[DATA_W-2:0], 1'b0};
    end else if (state_r == TX_WAIT_SYNC) begin
      shift_r  <= '0;
      dacdat_r <= 1'b0;
    end else begin
      dacdat_r <= shift_r[DATA_W-1];
      shift_r  <= {shift_r[DATA_W-2:0], 1'b0};
    end
  end

  // One-cycle marker for each frame taken from the FIFO.
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= pop_s;
    end
  end

  // Sticky underrun flag; a new underrun wins over a clear in the same cycle.
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      underrun_r <= 1'b0;
    end else if (underrun_set_s) begin
      underrun_r <= 1'b1;
    end else if (i_clr_underrun) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= underrun_r;
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx. A codec-side model captures DACDAT
// one BCLK after the DUT drives it and compares each slot's word with a
// frame queue model of the FIFO and the underrun rule.
module tb_i2s_dac_tx;

  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } fr_t;

  logic        clk;
  logic        rst_n;
  logic        lrck;
  logic        en;
  logic        valid;
  logic        ready;
  logic [15:0] left;
  logic [15:0] right;
  logic        dacdat;
  logic        frame_start;
  logic        underrun;
  logic        clr;

  int  checks = 0;
  int  errors = 0;
  int  fs_seen = 0;
  int  fs_exp = 0;
  fr_t src_q[$];
  fr_t exp_q[$];
  fr_t cur;
  fr_t last_pop;
  bit  synced;
  bit  ur;
  bit  acc_pend;

  i2s_dac_tx #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_AUD_BCLK     (clk),
    .i_rst_n        (rst_n),
    .i_AUD_DACLRCK  (lrck),
    .i_en           (en),
    .i_valid        (valid),
    .o_ready        (ready),
    .i_left         (left),
    .i_right        (right),
    .o_AUD_DACDAT   (dacdat),
    .o_frame_start  (frame_start),
    .o_underrun     (underrun),
    .i_clr_underrun (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Producer: offer the head of src_q; a frame counts as accepted when
  // valid and ready are both high going into the next rising edge.
  task automatic prod_step();
    if (acc_pend && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0) begin
      valid = 1'b1;
      left  = src_q[0].l;
      right = src_q[0].r;
    end else begin
      valid = 1'b0;
      left  = 16'h0000;
      right = 16'h0000;
    end
    acc_pend = valid && ready;
    if (acc_pend) exp_q.push_back(src_q[0]);
  endtask

  task automatic tick();
    @(negedge clk);
    chk("ready", ready, (exp_q.size() < FIFO_DEPTH));
    if (frame_start) fs_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      prod_step();
      tick();
    end
  endtask

  // One LRCK slot of len BCLKs; rst_at >= 0 pulses reset inside the slot.
  task automatic run_slot(input logic lr, input int len, input int rst_at, input string tag);
    logic [15:0] wexp;
    logic [15:0] got;
    logic [15:0] expw;
    logic        tail;
    bit          pop_now;
    bit          ls;
    ls      = en && (lr == 1'b0) && (lrck == 1'b1);
    pop_now = 1'b0;
    if (!en) synced = 1'b0;
    if (ls) begin
      synced = 1'b1;
      if (exp_q.size() > 0) begin
        cur      = exp_q.pop_front();
        last_pop = cur;
        pop_now  = 1'b1;
        fs_exp++;
      end else begin
        ur = 1'b1;
`ifdef I2S_DAC_TX_UNDERRUN_HOLD_EN
        cur = last_pop;
`else
        cur = '0;
`endif
      end
    end
    lrck = lr;
    wexp = lr ? cur.r : cur.l;
    prod_step();
    got  = 16'h0000;
    expw = 16'h0000;
    tail = 1'b0;
    for (int j = 0; j < len; j++) begin
      tick();
      if (j == 0) begin
        chk({tag, "_fstart"}, frame_start, pop_now);
        chk({tag, "_underrun"}, underrun, ur);
      end
      if (j < DATA_W) begin
        got[15-j]  = dacdat;
        expw[15-j] = synced ? wexp[15-j] : 1'b0;
      end else begin
        tail = tail | dacdat;
      end
      if (j == rst_at) begin
        rst_n = 1'b0;
        src_q.delete();
        exp_q.delete();
        synced   = 1'b0;
        ur       = 1'b0;
        cur      = '0;
        last_pop = '0;
        #1;
        chk("rst_dacdat", dacdat, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_underrun", underrun, 1'b0);
      end
      if (j == rst_at + 2) rst_n = 1'b1;
      if (j < len - 1) prod_step();
    end
    chk({tag, "_word"}, got, expw);
    chk({tag, "_tail"}, tail, 1'b0);
  endtask

  task automatic clr_ur();
    clr = 1'b1;
    prod_step();
    tick();
    clr = 1'b0;
    ur  = 1'b0;
    chk("clr_underrun", underrun, 1'b0);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; lrck = 1'b1; en = 1'b1; valid = 1'b0; clr = 1'b0;
    left = 16'h0000; right = 16'h0000;
    synced = 1'b0; ur = 1'b0; acc_pend = 1'b0; cur = '0; last_pop = '0;
    repeat (3) @(negedge clk);
    chk("reset_dacdat", dacdat, 1'b0);
    chk("reset_ready", ready, 1'b1);
    chk("reset_fstart", frame_start, 1'b0);
    chk("reset_underrun", underrun, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Basic frame, LRCK high after reset: the first right slot stays silent.
    src_q.push_back({16'h8001, 16'h7FFE});
    idle(4);
    run_slot(1'b1, 32, -1, "sync_r");
    run_slot(1'b0, 32, -1, "a_l");
    run_slot(1'b1, 32, -1, "a_r");
    chk("a_l_const", last_pop.l, 16'h8001);
    chk("fs_once", fs_seen, 1);

    // Three frames back-to-back into a two-deep FIFO.
    src_q.push_back({16'hA5A5, 16'h5A5A});
    src_q.push_back({16'h0F0F, 16'hF0F0});
    src_q.push_back({16'h1357, 16'h2468});
    idle(6);
    chk("ready_full", ready, 1'b0);
    chk("third_held", src_q.size(), 1);
    for (int k = 0; k < 3; k++) begin
      run_slot(1'b0, 32, -1, "ord_l");
      run_slot(1'b1, 32, -1, "ord_r");
    end

    // Last frame then starve the FIFO.
    src_q.push_back({16'h1234, 16'h5678});
    idle(4);
    run_slot(1'b0, 32, -1, "last_l");
    run_slot(1'b1, 32, -1, "last_r");
    run_slot(1'b0, 32, -1, "ur_l");
    chk("ur_flag", underrun, 1'b1);
    run_slot(1'b1, 32, -1, "ur_r");
    clr_ur();

    // Short slots truncate to the MSBs.
    src_q.push_back({16'($urandom()), 16'($urandom())});
    src_q.push_back({16'($urandom()), 16'($urandom())});
    idle(4);
    for (int k = 0; k < 2; k++) begin
      run_slot(1'b0, 10, -1, "short_l");
      run_slot(1'b1, 10, -1, "short_r");
    end

    // Disable across a left slot, re-enable at a right slot.
    src_q.push_back({16'($urandom()), 16'($urandom())});
    idle(4);
    en = 1'b0;
    run_slot(1'b0, 32, -1, "dis_l");
    en = 1'b1;
    run_slot(1'b1, 32, -1, "reen_r");
    run_slot(1'b0, 32, -1, "reen_l");
    run_slot(1'b1, 32, -1, "reen_r2");

    // Random producer and slot lengths.
    for (int p = 0; p < 12; p++) begin
      if ($urandom_range(0, 3) != 0) src_q.push_back({16'($urandom()), 16'($urandom())});
      run_slot(1'b0, int'($urandom_range(10, 40)), -1, "rnd_l");
      run_slot(1'b1, int'($urandom_range(10, 40)), -1, "rnd_r");
      if (p == 5) clr_ur();
    end

    // Reset in the middle of a left slot, then resynchronize.
    src_q.delete();
    src_q.push_back({16'hC3C3, 16'h3C3C});
    idle(6);
    run_slot(1'b0, 32, 5, "rst_l");
    src_q.push_back({16'h4321, 16'h8765});
    idle(4);
    run_slot(1'b1, 32, -1, "post_r");
    run_slot(1'b0, 32, -1, "post_l");
    run_slot(1'b1, 32, -1, "post_r2");
    chk("post_frame", last_pop, {16'h4321, 16'h8765});
    chk("fs_count", fs_seen, fs_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
